lc3_fetch_prefetch: RTL and testbench
=====================================

Name: lc3_fetch_prefetch

Overview:
- Parametrised next-generation LC-3 fetch unit.
- Keeps a DEPTH-entry prefetch queue filled from instruction memory, using a req/gnt request channel and an in-order response channel.
- Delivers instructions to decode over a valid/ready handshake.
- Resolves BR/JSR/JMP redirects: flushes the queue and discards responses still in flight. Sits between instruction memory and the decode stage.

Parameters:
ADDR_W, 16, address/PC width
DATA_W, 16, instruction width
DEPTH, 4, prefetch queue entries and max outstanding requests; power of 2, >=2
RESET_PC, 16'h3000, PC loaded on reset (truncated to ADDR_W)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_req  out  1  fetch request valid
mem_addr  out  ADDR_W  fetch address (= pc)
mem_we  out  1  write enable, constant 0
mem_gnt  in  1  memory accepts request this cycle
mem_rvalid  in  1  response valid (in order, any latency >=1)
mem_rdata  in  DATA_W  response instruction
out_valid  out  1  queue head valid
out_inst  out  DATA_W  head instruction
out_pc  out  ADDR_W  address of head instruction
out_ready  in  1  decode consumes head
redirect_valid  in  1  control-flow instruction resolved this cycle
opCode_in  in  4  opcode of resolved instruction
offset_in  in  11  PCoffset11 (BR uses [8:0])
reg_in  in  ADDR_W  base register value (JMP/RET/JSRR)
redirect_pc  in  ADDR_W  incremented PC of resolved instruction
br_nzp  in  3  BR condition bits
result_nzp  in  3  current condition codes
redirect_taken  out  1  registered pulse: redirect applied
pc  out  ADDR_W  next fetch address

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: pc=RESET_PC, resp_pc=RESET_PC, queue count=0, outstanding=0, drop_cnt=0, redirect_taken=0.
- Outputs during reset: mem_req=0, out_valid=0, out_inst=0, out_pc=0, mem_we=0.
- Reset mid-operation: clears all state; memory is reset in the same cycle.
- Issue:
  - mem_req=1 when (count+outstanding)<DEPTH and no taken redirect this cycle. mem_addr=pc, combinational.
  - On mem_req&mem_gnt: pc<=pc+1 (wraps modulo 2^ADDR_W), outstanding+1.
- Response:
  - On mem_rvalid with drop_cnt>0: discard the response, drop_cnt-1, outstanding-1.
  - Otherwise: push {mem_rdata, resp_pc} into the queue, resp_pc+1, outstanding-1.
  - Issue rule guarantees no overflow.
  - mem_rvalid with outstanding=0 is ignored.
- Output:
  - out_valid=(count>0); out_inst/out_pc come from the queue head, registered storage.
  - Pop on out_valid&out_ready.
  - Push and pop in the same cycle: count unchanged.
  - First instruction reaches out_valid one cycle after its mem_rvalid.
- Redirect, evaluated only when redirect_valid=1:
  - 0000 BR: taken iff |(br_nzp & result_nzp). Target = redirect_pc + sext(offset_in[8:0]).
  - 0100 JSR: always taken. Target = redirect_pc + sext(offset_in[10:0]).
  - 1100 JMP/RET/JSRR: always taken. Target = reg_in.
  - Any other opcode, or BR not taken: no effect.
- Taken redirect, same edge:
  - Queue flushed (count=0); any pop that cycle is void.
  - pc<=target, resp_pc<=target.
  - drop_cnt<=outstanding minus 1 if a response arrives that cycle (that response is itself discarded).
  - mem_req forced 0 that cycle.
  - redirect_taken=1 for exactly the next cycle.
  - Fetch from target begins the following cycle, even while drops are pending; drops are always consumed before new pushes because responses are in order.
- Address arithmetic: modulo 2^ADDR_W; offsets are sign-extended to ADDR_W.
- Back-to-back redirects: each applies fully; the later one overrides pc.

Test Plan:
- Reset, then memory grants every cycle with 1-cycle latency (rdata=addr^16'hA5A5), out_ready=1 -> out_pc sequence 3000,3001,3002..., first out_valid 2 cycles after first grant, mem_we=0 throughout.
- out_ready=0 with continuous grants -> exactly DEPTH=4 requests issued (3000..3003), then mem_req=0, count=4; out_ready=1 -> issue resumes at 3004 with no loss or duplication.
- BR n=1, result_nzp=100, redirect_pc=3005, offset=9'h1FE, while 2 responses are in flight -> redirect_taken pulse, pc=3003, queue empty, both stale responses dropped, next out_pc=3003.
- BR br_nzp=010, result_nzp=001 -> no flush, stream continues unchanged, redirect_taken=0.
- JMP reg_in=16'hFFFF -> fetch FFFF then 0000 (wrap); JSR redirect_pc=3010, offset=11'h400 -> target 2C10.
- rst asserted mid-stream with full queue and outstanding requests -> next cycle out_valid=0, mem_req=0, pc=3000; after release, fetch restarts at 3000.

Source files
------------

// File: rtl/lc3_fetch_prefetch.sv
// LC-3 fetch unit with a prefetch queue. Requests go out over a req/gnt channel and
// responses return in order. Each queued instruction carries its own address, and decode
// pops the head over a valid/ready handshake. A resolved BR/JSR/JMP flushes the queue,
// repoints the PC and discards the responses that are still in flight.
module lc3_fetch_prefetch #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h3000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready,
    input  logic              redirect_valid,
    input  logic [3:0]        opCode_in,
    input  logic [10:0]       offset_in,
    input  logic [ADDR_W-1:0] reg_in,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic [2:0]        br_nzp,
    input  logic [2:0]        result_nzp,
    output logic              redirect_taken,
    output logic [ADDR_W-1:0] pc
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);
    localparam logic [CntW:0] DepthW = (CntW + 1)'(DEPTH);

    logic [ADDR_W-1:0] pc_q, resp_pc_q;
    logic [CntW-1:0]   count_q, count_d, outst_q, outst_d, drop_q, drop_d;
    logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
    logic              redirect_taken_q;
    logic [DATA_W-1:0] inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q [DEPTH];

    logic              taken;
    logic [ADDR_W-1:0] target;
    logic              room, issue, rsp, drop, push, pop, head_valid;

    // Decode the resolved control-flow instruction into taken/target.
    always_comb begin
        taken  = 1'b0;
        target = reg_in;
        if (redirect_valid) begin
            case (opCode_in)
                4'b0000: begin
                    taken  = |(br_nzp & result_nzp);
                    target = redirect_pc + {{(ADDR_W-9){offset_in[8]}}, offset_in[8:0]};
                end
                4'b0100: begin
                    taken  = 1'b1;
                    target = redirect_pc + {{(ADDR_W-11){offset_in[10]}}, offset_in};
                end
                4'b1100: begin
                    taken  = 1'b1;
                    target = reg_in;
                end
                default: begin
                    taken  = 1'b0;
                    target = reg_in;
                end
            endcase
        end
    end

    // Handshake qualifiers and next-state counters.
    always_comb begin
        // Queued plus in-flight never exceeds DEPTH, so a push can never overflow.
        room       = ({1'b0, count_q} + {1'b0, outst_q}) < DepthW;
        mem_req    = !rst && room && !taken;
        issue      = mem_req && mem_gnt;
        rsp        = mem_rvalid && (outst_q != '0);
        drop       = rsp && (drop_q != '0);
        push       = rsp && !drop && !taken;
        head_valid = (count_q != '0);
        pop        = head_valid && out_ready && !taken;
        outst_d    = outst_q + CntW'(issue) - CntW'(rsp);
        count_d    = taken ? '0 : count_q + CntW'(push) - CntW'(pop);
        // A response arriving alongside the redirect is already discarded via push=0.
        drop_d     = taken ? outst_q - CntW'(rsp) : drop_q - CntW'(drop);
    end

    // Control state: PCs, occupancy, pointers and the redirect pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q             <= ResetPc;
            resp_pc_q        <= ResetPc;
            count_q          <= '0;
            outst_q          <= '0;
            drop_q           <= '0;
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            redirect_taken_q <= 1'b0;
        end else begin
            count_q          <= count_d;
            outst_q          <= outst_d;
            drop_q           <= drop_d;
            redirect_taken_q <= taken;
            if (taken) begin
                pc_q      <= target;
                resp_pc_q <= target;
                rd_ptr_q  <= '0;
                wr_ptr_q  <= '0;
            end else begin
                if (issue) pc_q <= pc_q + 1'b1;
                if (push) begin
                    resp_pc_q <= resp_pc_q + 1'b1;
                    wr_ptr_q  <= wr_ptr_q + 1'b1;
                end
                if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Queue storage. It needs no reset because occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= mem_rdata;
            pc_mem_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

    // Output drive. The head is gated to zero while reset is held.
    always_comb begin
        mem_addr       = pc_q;
        mem_we         = 1'b0;
        pc             = pc_q;
        redirect_taken = redirect_taken_q;
        out_valid      = !rst && head_valid;
        out_inst       = rst ? '0 : inst_mem_q[rd_ptr_q];
        out_pc         = rst ? '0 : pc_mem_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_lc3_fetch_prefetch.sv
// Bench for lc3_fetch_prefetch. A transaction-level model built from queues tracks the
// expected outputs every cycle. A memory model answers the grants, and directed sequences
// plus a redirect table cover the corner cases.
module tb_lc3_fetch_prefetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [15:0] mem_addr, mem_rdata;
    logic        out_valid, out_ready;
    logic [15:0] out_inst, out_pc;
    logic        redirect_valid;
    logic [3:0]  opCode_in;
    logic [10:0] offset_in;
    logic [15:0] reg_in, redirect_pc;
    logic [2:0]  br_nzp, result_nzp;
    logic        redirect_taken;
    logic [15:0] pc;

    lc3_fetch_prefetch #(
        .ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .RESET_PC(16'h3000)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready),
        .redirect_valid(redirect_valid), .opCode_in(opCode_in), .offset_in(offset_in),
        .reg_in(reg_in), .redirect_pc(redirect_pc), .br_nzp(br_nzp), .result_nzp(result_nzp),
        .redirect_taken(redirect_taken), .pc(pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] inst; logic [15:0] addr; } ent_t;
    typedef struct { logic [15:0] addr; int cyc; } pend_t;
    typedef struct {
        logic [3:0]  op;
        logic [10:0] off;
        logic [15:0] rin;
        logic [15:0] rpc;
        logic [2:0]  bn;
        logic [2:0]  rn;
        logic        tk;
        logic [15:0] epc;
    } vec_t;

    ent_t        m_q[$];
    pend_t       pend[$];
    logic [15:0] m_pc, m_rpc;
    int          m_out, m_drop;
    bit          m_rt, m_known;
    int          errors = 0, checks = 0, cyc = 0, gnt_pct = 100, rsp_pct = 100, issue_cnt = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Redirect rules computed with signed integer arithmetic.
    function automatic void m_redirect(output bit tk, output logic [15:0] tgt);
        int off;
        tk  = 1'b0;
        tgt = 16'h0;
        if (redirect_valid) begin
            if (opCode_in == 4'b0000) begin
                off = 32'(offset_in[8:0]);
                if (off >= 256) off -= 512;
                tk  = (br_nzp & result_nzp) != 3'b000;
                tgt = 16'(int'(redirect_pc) + off);
            end else if (opCode_in == 4'b0100) begin
                off = 32'(offset_in);
                if (off >= 1024) off -= 2048;
                tk  = 1'b1;
                tgt = 16'(int'(redirect_pc) + off);
            end else if (opCode_in == 4'b1100) begin
                tk  = 1'b1;
                tgt = reg_in;
            end
        end
    endfunction

    task automatic idle_redir();
        redirect_valid = 1'b0;
        opCode_in      = 4'h0;
        offset_in      = 11'h0;
        reg_in         = 16'h0;
        redirect_pc    = 16'h0;
        br_nzp         = 3'b000;
        result_nzp     = 3'b000;
    endtask

    // One clock cycle. Entered at a negedge, it checks the outputs, advances the model and
    // returns at the next negedge.
    task automatic tick();
        bit          tk, exp_req, rsp;
        logic [15:0] tgt;
        int          out_pre;
        if (rst) begin
            pend.delete();
            mem_rvalid = 1'b0;
        end else if (pend.size() > 0 && pend[0].cyc < cyc && $urandom_range(99) < rsp_pct) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend[0].addr ^ 16'hA5A5;
            void'(pend.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 16'($urandom);
        end
        mem_gnt = ($urandom_range(99) < gnt_pct);
        #1;
        m_redirect(tk, tgt);
        exp_req = !rst && (m_q.size() + m_out < DEPTH) && !tk;
        if (m_known) begin
            chk("mem_we", 32'(mem_we), 32'd0);
            chk("mem_req", 32'(mem_req), 32'(exp_req));
            if (exp_req) chk("mem_addr", 32'(mem_addr), 32'(m_pc));
            chk("pc", 32'(pc), 32'(m_pc));
            chk("out_valid", 32'(out_valid), 32'(!rst && m_q.size() > 0));
            if (rst) begin
                chk("out_inst_rst", 32'(out_inst), 32'd0);
                chk("out_pc_rst", 32'(out_pc), 32'd0);
            end else if (m_q.size() > 0) begin
                chk("out_inst", 32'(out_inst), 32'(m_q[0].inst));
                chk("out_pc", 32'(out_pc), 32'(m_q[0].addr));
            end
            chk("redirect_taken", 32'(redirect_taken), 32'(m_rt));
        end
        if (!rst && mem_req && mem_gnt) begin
            pend.push_back('{mem_addr, cyc});
            issue_cnt++;
        end
        if (rst) begin
            m_q.delete();
            m_pc    = 16'h3000;
            m_rpc   = 16'h3000;
            m_out   = 0;
            m_drop  = 0;
            m_rt    = 1'b0;
            m_known = 1'b1;
        end else begin
            rsp     = mem_rvalid && m_out > 0;
            out_pre = m_out;
            if (!tk && m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            if (rsp) begin
                if (m_drop > 0) m_drop--;
                else if (!tk) begin
                    m_q.push_back('{m_rpc ^ 16'hA5A5, m_rpc});
                    m_rpc++;
                end
                m_out--;
            end
            if (exp_req && mem_gnt) begin
                m_pc++;
                m_out++;
            end
            if (tk) begin
                m_q.delete();
                m_pc   = tgt;
                m_rpc  = tgt;
                m_drop = out_pre - int'(rsp);
            end
            m_rt = tk;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    vec_t vec[10];

    initial begin
        vec[0] = '{4'b0000, 11'h1FE, 16'h0000, 16'h3005, 3'b100, 3'b100, 1'b1, 16'h3003};
        vec[1] = '{4'b0000, 11'h1FE, 16'h0000, 16'h3005, 3'b010, 3'b001, 1'b0, 16'h3000};
        vec[2] = '{4'b0000, 11'h005, 16'h0000, 16'h3005, 3'b111, 3'b000, 1'b0, 16'h3000};
        vec[3] = '{4'b0000, 11'h0FF, 16'h0000, 16'h3000, 3'b001, 3'b001, 1'b1, 16'h30FF};
        vec[4] = '{4'b0100, 11'h400, 16'h0000, 16'h3010, 3'b000, 3'b000, 1'b1, 16'h2C10};
        vec[5] = '{4'b0100, 11'h3FF, 16'h0000, 16'h3010, 3'b000, 3'b000, 1'b1, 16'h340F};
        vec[6] = '{4'b1100, 11'h000, 16'hFFFF, 16'h3010, 3'b000, 3'b000, 1'b1, 16'hFFFF};
        vec[7] = '{4'b0010, 11'h010, 16'h1234, 16'h3010, 3'b111, 3'b111, 1'b0, 16'h3000};
        vec[8] = '{4'b0000, 11'h100, 16'h0000, 16'h0080, 3'b011, 3'b010, 1'b1, 16'hFF80};
        vec[9] = '{4'b1000, 11'h010, 16'h1234, 16'h3010, 3'b111, 3'b111, 1'b0, 16'h3000};

        rst = 1'b1; out_ready = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0;
        idle_redir();
        m_known = 1'b0; m_rt = 1'b0; m_out = 0; m_drop = 0;
        m_pc = 16'h0; m_rpc = 16'h0;
        @(negedge clk);

        // Reset state, then a continuous stream with 1-cycle memory latency.
        do_reset();
        chk("reset_pc", 32'(pc), 32'h3000);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_taken", 32'(redirect_taken), 32'd0);
        gnt_pct = 100; rsp_pct = 100; out_ready = 1'b1;
        tick();
        chk("first_valid_early", 32'(out_valid), 32'd0);
        tick();
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_pc", 32'(out_pc), 32'h3000);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("stream_pc", 32'(out_pc), 32'h3000 + 32'(i));
            chk("stream_inst", 32'(out_inst), (32'h3000 + 32'(i)) ^ 32'hA5A5);
        end

        // Backpressure: the queue fills to DEPTH and issue stops.
        do_reset();
        out_ready = 1'b0;
        issue_cnt = 0;
        repeat (8) tick();
        chk("bp_issue_cnt", 32'(issue_cnt), 32'd4);
        chk("bp_pc", 32'(pc), 32'h3004);
        chk("bp_mem_req", 32'(mem_req), 32'd0);
        chk("bp_head", 32'(out_pc), 32'h3000);
        out_ready = 1'b1;
        repeat (10) tick();

        // Taken BR with two responses in flight.
        do_reset();
        rsp_pct = 0;
        tick();
        tick();
        redirect_valid = 1'b1; opCode_in = 4'b0000; offset_in = 11'h1FE;
        redirect_pc = 16'h3005; br_nzp = 3'b100; result_nzp = 3'b100;
        tick();
        idle_redir();
        chk("br_taken_pulse", 32'(redirect_taken), 32'd1);
        chk("br_pc", 32'(pc), 32'h3003);
        chk("br_flush", 32'(out_valid), 32'd0);
        rsp_pct = 100;
        tick();
        chk("br_pulse_end", 32'(redirect_taken), 32'd0);
        for (int i = 0; i < 10 && !out_valid; i++) tick();
        chk("br_valid", 32'(out_valid), 32'd1);
        chk("br_head_pc", 32'(out_pc), 32'h3003);

        // Not-taken BR leaves the stream alone.
        repeat (3) tick();
        redirect_valid = 1'b1; opCode_in = 4'b0000; offset_in = 11'h1FE;
        redirect_pc = 16'h3005; br_nzp = 3'b010; result_nzp = 3'b001;
        tick();
        idle_redir();
        chk("br_nt_pulse", 32'(redirect_taken), 32'd0);
        chk("br_nt_valid", 32'(out_valid), 32'd1);

        // JMP to FFFF, then the PC wraps to 0000.
        redirect_valid = 1'b1; opCode_in = 4'b1100; reg_in = 16'hFFFF;
        tick();
        idle_redir();
        chk("jmp_pc", 32'(pc), 32'hFFFF);
        tick();
        chk("jmp_wrap_pc", 32'(pc), 32'h0000);
        for (int i = 0; i < 10 && !out_valid; i++) tick();
        chk("jmp_head", 32'(out_pc), 32'hFFFF);
        tick();
        chk("jmp_head_wrap", 32'(out_pc), 32'h0000);

        // Reset mid-stream with queued and outstanding entries.
        do_reset();
        out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_pc", 32'(pc), 32'h3000);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("restart_req", 32'(mem_req), 32'd1);
        chk("restart_addr", 32'(mem_addr), 32'h3000);
        repeat (6) tick();

        // Redirect decode table, applied from a quiet reset state.
        gnt_pct = 0;
        for (int i = 0; i < 10; i++) begin
            do_reset();
            redirect_valid = 1'b1; opCode_in = vec[i].op; offset_in = vec[i].off;
            reg_in = vec[i].rin; redirect_pc = vec[i].rpc;
            br_nzp = vec[i].bn; result_nzp = vec[i].rn;
            tick();
            idle_redir();
            chk("vec_taken", 32'(redirect_taken), 32'(vec[i].tk));
            chk("vec_pc", 32'(pc), 32'(vec[i].epc));
        end

        // Randomised traffic, redirects and resets against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 0) begin
                gnt_pct = 40 + 20 * ((i / 100) % 3);
                rsp_pct = 90 - 20 * ((i / 100) % 3);
            end
            rst       = ($urandom_range(199) == 0);
            out_ready = ($urandom_range(3) != 0);
            if ($urandom_range(14) == 0) begin
                redirect_valid = 1'b1;
                case ($urandom_range(3))
                    0:       opCode_in = 4'b0000;
                    1:       opCode_in = 4'b0100;
                    2:       opCode_in = 4'b1100;
                    default: opCode_in = 4'($urandom);
                endcase
                offset_in   = 11'($urandom);
                reg_in      = 16'($urandom);
                redirect_pc = 16'($urandom);
                br_nzp      = 3'($urandom);
                result_nzp  = 3'($urandom);
            end else begin
                idle_redir();
            end
            tick();
        end
        rst = 1'b0;
        idle_redir();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
